// File: rtl/sram_port_arbiter_if.sv
// Bus bundle for sram_port_arbiter: I fetch port, D data port and SRAM macro side.
// slave  = arbiter view, master = requesters / SRAM macro view.
interface sram_port_arbiter_if #(
  parameter int unsigned NB_COL    = 4,
  parameter int unsigned COL_WIDTH = 8,
  parameter int unsigned ADDR_W    = 13
);
  localparam int unsigned DW = NB_COL * COL_WIDTH;

  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_rsp_valid;
  logic [DW-1:0]     i_rsp_rdata;
  logic              i_rsp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic [NB_COL-1:0] d_req_we;
  logic [DW-1:0]     d_req_wdata;
  logic              d_rsp_valid;
  logic [DW-1:0]     d_rsp_rdata;
  logic              d_rsp_err;

  logic              sram_en;
  logic [NB_COL-1:0] sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DW-1:0]     sram_din;
  logic [DW-1:0]     sram_dout;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    output sram_en, sram_we, sram_addr, sram_din,
    input  sram_dout
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
    input  sram_en, sram_we, sram_addr, sram_din,
    output sram_dout
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port read-first byte-write SRAM between
// an instruction fetch port (I, read-only) and a data port (D, read/write).
// Requests are granted combinationally, the SRAM is accessed in the grant
// cycle and the response is routed to its owner exactly one cycle later.
// Out-of-range addresses are accepted but answered with err=1 and rdata=0.
// Optional: define ARB_ROUND_ROBIN_EN for alternating priority instead of
// D-priority with the MAX_WAIT starvation guard.
module sram_port_arbiter #(
  parameter int unsigned NB_COL    = 4,
  parameter int unsigned COL_WIDTH = 8,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned RAM_DEPTH = 8192,
  parameter int unsigned MAX_WAIT  = 4
) (
  input logic               clk,
  input logic               rst_n,
  sram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   err_q, err_d;
  logic   grant_i, grant_d;
  logic   i_in_range, d_in_range;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;
`else
  logic [3:0] wait_cnt_q, wait_cnt_d;
`endif

  // Address range checks for both request ports
  always_comb begin
    i_in_range = (32'(bus.i_req_addr) < RAM_DEPTH);
    d_in_range = (32'(bus.d_req_addr) < RAM_DEPTH);
  end

  // Grant selection and arbiter state update
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
    if (bus.i_req_valid && bus.d_req_valid) begin
      if (last_d_q) grant_i = 1'b1;
      else          grant_d = 1'b1;
    end else if (bus.i_req_valid) begin
      grant_i = 1'b1;
    end else if (bus.d_req_valid) begin
      grant_d = 1'b1;
    end
    if (grant_i)      last_d_d = 1'b0;
    else if (grant_d) last_d_d = 1'b1;
`else
    wait_cnt_d = wait_cnt_q;
    if (bus.i_req_valid && (wait_cnt_q == 4'(MAX_WAIT))) begin
      grant_i = 1'b1;
    end else if (bus.d_req_valid) begin
      grant_d = 1'b1;
    end else if (bus.i_req_valid) begin
      grant_i = 1'b1;
    end
    if (!bus.i_req_valid || grant_i) begin
      wait_cnt_d = '0;
    end else if (grant_d && (wait_cnt_q != 4'(MAX_WAIT))) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
`endif
    bus.i_req_ready = grant_i;
    bus.d_req_ready = grant_d;
  end

  // SRAM drive for the granted request and next-cycle response tag
  always_comb begin
    bus.sram_en   = 1'b0;
    bus.sram_we   = '0;
    bus.sram_addr = '0;
    bus.sram_din  = '0;
    owner_d       = OWN_NONE;
    err_d         = 1'b0;
    if (grant_d) begin
      owner_d = OWN_D;
      err_d   = !d_in_range;
      if (d_in_range) begin
        bus.sram_en   = 1'b1;
        bus.sram_we   = bus.d_req_we;
        bus.sram_addr = bus.d_req_addr;
        bus.sram_din  = bus.d_req_wdata;
      end
    end else if (grant_i) begin
      owner_d = OWN_I;
      err_d   = !i_in_range;
      if (i_in_range) begin
        bus.sram_en   = 1'b1;
        bus.sram_addr = bus.i_req_addr;
      end
    end
  end

  // Response routing: SRAM data goes only to the owner of an in-range access
  always_comb begin
    bus.i_rsp_valid = (owner_q == OWN_I);
    bus.d_rsp_valid = (owner_q == OWN_D);
    bus.i_rsp_err   = bus.i_rsp_valid && err_q;
    bus.d_rsp_err   = bus.d_rsp_valid && err_q;
    bus.i_rsp_rdata = (bus.i_rsp_valid && !err_q) ? bus.sram_dout : '0;
    bus.d_rsp_rdata = (bus.d_rsp_valid && !err_q) ? bus.sram_dout : '0;
  end

  // State registers; reset drops any response in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b1;
`else
      wait_cnt_q <= '0;
`endif
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`else
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: behavioural SRAM, shadow-memory
// reference model, directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
  localparam int unsigned NB_COL    = 4;
  localparam int unsigned COL_WIDTH = 8;
  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned RAM_DEPTH = 8192;
  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned DW        = NB_COL * COL_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .ADDR_W(ADDR_W)) bus ();

  sram_port_arbiter #(
    .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .ADDR_W(ADDR_W),
    .RAM_DEPTH(RAM_DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  function automatic logic [DW-1:0] init_word(input int unsigned a);
    return DW'(a * 32'h9E3779B9) ^ DW'(32'h0BADF00D);
  endfunction

  // Behavioural SRAM macro: registered read, read-first, byte writes
  logic [DW-1:0] sram_mem [0:(1<<ADDR_W)-1];
  bit            sram_vld [0:(1<<ADDR_W)-1];
  logic [DW-1:0] sram_cur;
  always @(posedge clk) begin
    if (bus.sram_en) begin
      sram_cur = sram_vld[bus.sram_addr] ? sram_mem[bus.sram_addr] : init_word(bus.sram_addr);
      bus.sram_dout <= sram_cur;
      for (int b = 0; b < NB_COL; b++)
        if (bus.sram_we[b]) sram_cur[b*COL_WIDTH +: COL_WIDTH] = bus.sram_din[b*COL_WIDTH +: COL_WIDTH];
      sram_mem[bus.sram_addr] <= sram_cur;
      sram_vld[bus.sram_addr] <= 1'b1;
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:RAM_DEPTH-1];
  int unsigned   starve;      // D grants I has sat through while waiting
  bit            last_was_d;  // round-robin history
  bit            pend_v, pend_i, pend_err;
  logic [DW-1:0] pend_data;
  bit            obs_i_v, obs_d_v, obs_i_err, obs_d_err;
  logic [DW-1:0] obs_i_rdata, obs_d_rdata;
  int            checks   = 0;
  int            failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.d_req_valid = 1'b0;
    bus.d_req_addr  = '0;
    bus.d_req_we    = '0;
    bus.d_req_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    pend_v     = 1'b0;
    starve     = 0;
    last_was_d = 1'b1;
    #1;
    check_eq("rst_ready", {bus.i_req_ready, bus.d_req_ready}, 0);
    check_eq("rst_rsp_ctl", {bus.i_rsp_valid, bus.i_rsp_err, bus.d_rsp_valid, bus.d_rsp_err}, 0);
    check_eq("rst_rsp_data", {bus.i_rsp_rdata, bus.d_rsp_rdata}, 0);
    check_eq("rst_sram_ctl", {bus.sram_en, bus.sram_we, bus.sram_addr}, 0);
    check_eq("rst_sram_din", bus.sram_din, 0);
  endtask

  // One clock cycle: check the response due now, drive a request, check grant
  // and SRAM drive against the model, then record the response due next cycle.
  task automatic step(input bit iv, input logic [ADDR_W-1:0] ia,
                      input bit dv, input logic [ADDR_W-1:0] da,
                      input logic [NB_COL-1:0] dwe, input logic [DW-1:0] dwd,
                      output bit gi, output bit gd);
    bit ei, ed, ok, in_rng;
    logic [ADDR_W-1:0] ga;
    @(negedge clk);
    check_eq("i_rsp_valid", bus.i_rsp_valid, pend_v && pend_i);
    check_eq("d_rsp_valid", bus.d_rsp_valid, pend_v && !pend_i);
    check_eq("i_rsp_err", bus.i_rsp_err, pend_v && pend_i && pend_err);
    check_eq("d_rsp_err", bus.d_rsp_err, pend_v && !pend_i && pend_err);
    check_eq("i_rsp_rdata", bus.i_rsp_rdata, (pend_v && pend_i) ? pend_data : '0);
    check_eq("d_rsp_rdata", bus.d_rsp_rdata, (pend_v && !pend_i) ? pend_data : '0);
    obs_i_v = bus.i_rsp_valid; obs_i_err = bus.i_rsp_err; obs_i_rdata = bus.i_rsp_rdata;
    obs_d_v = bus.d_rsp_valid; obs_d_err = bus.d_rsp_err; obs_d_rdata = bus.d_rsp_rdata;

    bus.i_req_valid = iv;
    bus.i_req_addr  = ia;
    bus.d_req_valid = dv;
    bus.d_req_addr  = da;
    bus.d_req_we    = dwe;
    bus.d_req_wdata = dwd;
    #1;
    ei = iv; ed = dv;
    if (iv && dv) begin
`ifdef ARB_ROUND_ROBIN_EN
      ei = last_was_d;
`else
      ei = (starve >= MAX_WAIT);
`endif
      ed = !ei;
    end
    gi = bus.i_req_ready;
    gd = bus.d_req_ready;
    check_eq("i_req_ready", gi, ei);
    check_eq("d_req_ready", gd, ed);
    ga     = ei ? ia : da;
    in_rng = (ga < RAM_DEPTH);
    ok     = (ei || ed) && in_rng;
    check_eq("sram_en", bus.sram_en, ok);
    check_eq("sram_addr", bus.sram_addr, ok ? ga : '0);
    check_eq("sram_we", bus.sram_we, (ok && ed) ? dwe : '0);
    check_eq("sram_din", bus.sram_din, (ok && ed) ? dwd : '0);

    pend_v    = ei || ed;
    pend_i    = ei;
    pend_err  = pend_v && !in_rng;
    pend_data = '0;
    if (ok) begin
      pend_data = ref_mem[ga];
      if (ed)
        for (int b = 0; b < NB_COL; b++)
          if (dwe[b]) ref_mem[ga][b*COL_WIDTH +: COL_WIDTH] = dwd[b*COL_WIDTH +: COL_WIDTH];
    end
    if (!iv || ei)                   starve = 0;
    else if (ed && starve < MAX_WAIT) starve++;
    if (ei)      last_was_d = 1'b0;
    else if (ed) last_was_d = 1'b1;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 99) < 8) return ADDR_W'(RAM_DEPTH + $urandom_range(0, 8191));
    return ADDR_W'($urandom_range(0, 15));
  endfunction

  initial begin : main
    bit gi, gd, ip, dp;
    logic [ADDR_W-1:0] ia, da;
    logic [NB_COL-1:0] dwe;
    logic [DW-1:0]     dwd;
    drive_idle();
    for (int unsigned a = 0; a < RAM_DEPTH; a++) ref_mem[a] = init_word(a);

    do_reset();

    // Full-word write, read back, byte-lane merge
    step(0, 0, 1, 5, 4'b1111, 32'hDEADBEEF, gi, gd);
    step(0, 0, 1, 5, 4'b0000, 32'h0, gi, gd);
    step(0, 0, 0, 0, 4'b0000, 32'h0, gi, gd);
    check_eq("rd_full_word", obs_d_rdata, 32'hDEADBEEF);
    step(0, 0, 1, 5, 4'b0010, 32'h00005500, gi, gd);
    step(0, 0, 1, 5, 4'b0000, 32'h0, gi, gd);
    check_eq("wr_ack_old_data", obs_d_rdata, 32'hDEADBEEF);
    step(0, 0, 0, 0, 4'b0000, 32'h0, gi, gd);
    check_eq("rd_byte_merge", obs_d_rdata, 32'hDEAD55EF);

    // D write followed by I read of the same word
    step(0, 0, 1, 7, 4'b1111, 32'hCAFEF00D, gi, gd);
    step(1, 7, 0, 0, 4'b0000, 32'h0, gi, gd);
    step(0, 0, 0, 0, 4'b0000, 32'h0, gi, gd);
    check_eq("i_after_d_write", obs_i_rdata, 32'hCAFEF00D);

    // Out-of-range I read, then out-of-range D write
    step(1, 14'd8192, 0, 0, 4'b0000, 32'h0, gi, gd);
    check_eq("oor_i_ready", gi, 1);
    step(0, 0, 1, 14'd9000, 4'b1111, 32'h12345678, gi, gd);
    check_eq("oor_i_rsp", {obs_i_v, obs_i_err, obs_i_rdata}, {2'b11, 32'h0});
    step(0, 0, 0, 0, 4'b0000, 32'h0, gi, gd);
    check_eq("oor_d_rsp", {obs_d_v, obs_d_err, obs_d_rdata}, {2'b11, 32'h0});

    // Response pending when reset asserts is dropped
    step(0, 0, 1, 3, 4'b0000, 32'h0, gi, gd);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("drop_d_rsp", bus.d_rsp_valid, 0);
    do_reset();

    // Continuous contention right after reset
    for (int k = 0; k < 10; k++) begin
      step(1, 10, 1, 11, 4'b0000, 32'h0, gi, gd);
`ifdef ARB_ROUND_ROBIN_EN
      check_eq("grant_pattern", gi, (k % 2) == 0);
`else
      check_eq("grant_pattern", gi, (k % 5) == 4);
`endif
    end

    // Alternating single-port reads, no bubbles
    for (int k = 0; k < 8; k++) begin
      step((k % 2) == 0, ADDR_W'(20 + k), (k % 2) == 1, ADDR_W'(30 + k), 4'b0000, 32'h0, gi, gd);
      if (k > 0) check_eq("alt_routing", {obs_i_v, obs_d_v}, ((k - 1) % 2 == 0) ? 2'b10 : 2'b01);
    end

    // Randomized traffic; requesters hold valid/address until accepted
    ip = 1'b0; dp = 1'b0; ia = '0; da = '0; dwe = '0; dwd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!ip && $urandom_range(0, 99) < 60) begin ip = 1'b1; ia = rand_addr(); end
      if (!dp && $urandom_range(0, 99) < 60) begin
        dp  = 1'b1;
        da  = rand_addr();
        dwe = $urandom_range(0, 1) ? NB_COL'($urandom) : '0;
        dwd = $urandom;
      end
      step(ip, ia, dp, da, dwe, dwd, gi, gd);
      if (gi) ip = 1'b0;
      if (gd) dp = 1'b0;
    end
    step(0, 0, 0, 0, 4'b0000, 32'h0, gi, gd);
    step(0, 0, 0, 0, 4'b0000, 32'h0, gi, gd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
